register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_read_port.sv | 27 ++
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and types for the 4 x 16-bit CPU register file.
// Optional write-forwarding build is selected with REGFILE_BYPASS_EN.
package register_file_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 2;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef reg_data_t [NUM_REGS-1:0] reg_array_t;

endpackage

// File: rtl/register_file_read_port.sv
// Combinational read mux, zero latency, no backpressure; with REGFILE_BYPASS_EN
// a same-cycle write to the addressed register is forwarded to the output.
module register_file_read_port
    import register_file_pkg::*;
(
    input  reg_array_t regs_i,
    input  reg_addr_t  addr_i,
`ifdef REGFILE_BYPASS_EN
    input  logic       rst_n_i,
    input  logic       wr_en_i,
    input  reg_addr_t  wr_addr_i,
    input  reg_data_t  wr_data_i,
`endif
    output reg_data_t  data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
        // Gated by reset so the port reads zero while the array is held clear.
        if (rst_n_i && wr_en_i && (wr_addr_i == addr_i)) begin
            data_o = wr_data_i;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// 4 x 16-bit register file: two combinational read ports, one write port taking
// effect on the rising edge; no backpressure. REGFILE_BYPASS_EN adds write-forwarding.
module register_file
    import register_file_pkg::*;
(
    input  logic      Clock,
    input  logic      Reset_n,
    input  reg_addr_t RS,
    input  reg_addr_t RT,
    input  reg_addr_t RD,
    input  reg_data_t WriteData,
    input  logic      RegWrite,
    output reg_data_t ReadRS,
    output reg_data_t ReadRT
);

    reg_array_t regs_q;
    reg_array_t regs_d;

    always_comb begin
        regs_d = regs_q;
        if (RegWrite) begin
            regs_d[RD] = WriteData;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_port u_read_rs (
        .regs_i    (regs_q),
        .addr_i    (RS),
`ifdef REGFILE_BYPASS_EN
        .rst_n_i   (Reset_n),
        .wr_en_i   (RegWrite),
        .wr_addr_i (RD),
        .wr_data_i (WriteData),
`endif
        .data_o    (ReadRS)
    );

    register_file_read_port u_read_rt (
        .regs_i    (regs_q),
        .addr_i    (RT),
`ifdef REGFILE_BYPASS_EN
        .rst_n_i   (Reset_n),
        .wr_en_i   (RegWrite),
        .wr_addr_i (RD),
        .wr_data_i (WriteData),
`endif
        .data_o    (ReadRT)
    );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus random traffic against an array model.
module tb_register_file;

    logic        Clock;
    logic        Reset_n;
    logic [1:0]  RS, RT, RD;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic [15:0] ReadRS, ReadRT;

    int errors = 0;
    int checks = 0;

    logic [15:0] mdl [4];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_file dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One write committed on the next rising edge; the model follows the same rule.
    task automatic do_write(input logic [1:0] addr, input logic [15:0] data);
        @(negedge Clock);
        RD = addr; WriteData = data; RegWrite = 1'b1;
        @(posedge Clock);
        #1;
        mdl[addr] = data;
        RegWrite = 1'b0;
    endtask

    task automatic test_reset;
        // Initial reset state, held from time zero.
        for (int i = 0; i < 4; i++) begin
            RS = 2'(i); RT = 2'(3 - i);
            #1;
            checks++;
            if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000) begin
                errors++;
                $display("FAIL reset_init reg%0d: ReadRS=%h ReadRT=%h expected 0000", i, ReadRS, ReadRT);
            end
        end
        @(negedge Clock); #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        do_write(2'd0, 16'h1111);
        do_write(2'd1, 16'h2222);
        do_write(2'd2, 16'h3333);
        do_write(2'd3, 16'h4444);
        // Mid-cycle reset pulse while a write is requested.
        @(negedge Clock);
        RD = 2'd1; WriteData = 16'hDEAD; RegWrite = 1'b1;
        RS = 2'd1; RT = 2'd2;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_immediate: ReadRS=%h ReadRT=%h expected 0000", ReadRS, ReadRT);
        end
        @(posedge Clock); #1;
        checks++;
        if (ReadRS !== 16'h0000) begin
            errors++;
            $display("FAIL reset_over_write: ReadRS=%h expected 0000", ReadRS);
        end
        @(negedge Clock);
        RegWrite = 1'b0;
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            RS = 2'(i); RT = 2'(i);
            #1;
            checks++;
            if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000) begin
                errors++;
                $display("FAIL reset_cleared reg%0d: ReadRS=%h ReadRT=%h expected 0000", i, ReadRS, ReadRT);
            end
        end
    endtask

    task automatic test_basic;
        do_write(2'd1, 16'h1234);
        do_write(2'd2, 16'h1234);
        RS = 2'd0; RT = 2'd1;
        #1;
        checks++;
        if (ReadRS !== 16'h0000 || ReadRT !== 16'h1234) begin
            errors++;
            $display("FAIL basic_rw: ReadRS=%h ReadRT=%h expected 0000/1234", ReadRS, ReadRT);
        end
        RT = 2'd2;
        #1;
        checks++;
        if (ReadRT !== 16'h1234) begin
            errors++;
            $display("FAIL basic_rt2: ReadRT=%h expected 1234", ReadRT);
        end
    endtask

    task automatic test_write_disable;
        @(negedge Clock);
        RD = 2'd3; WriteData = 16'hBEEF; RegWrite = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        RS = 2'd3; RT = 2'd3;
        #1;
        checks++;
        if (ReadRS !== 16'h0000 || ReadRT !== 16'h0000) begin
            errors++;
            $display("FAIL write_disable: ReadRS=%h ReadRT=%h expected 0000", ReadRS, ReadRT);
        end
    endtask

    task automatic test_dual_read;
        do_write(2'd0, 16'hA5A5);
        RS = 2'd0; RT = 2'd0;
        #1;
        checks++;
        if (ReadRS !== 16'hA5A5 || ReadRT !== 16'hA5A5) begin
            errors++;
            $display("FAIL dual_read: ReadRS=%h ReadRT=%h expected A5A5", ReadRS, ReadRT);
        end
    endtask

    task automatic test_hazard;
        logic [15:0] exp_before;
        do_write(2'd2, 16'h1111);
        @(negedge Clock);
        RD = 2'd2; RS = 2'd2; RT = 2'd0; WriteData = 16'h2222; RegWrite = 1'b1;
        #1;
        exp_before = BYPASS ? 16'h2222 : 16'h1111;
        checks++;
        if (ReadRS !== exp_before) begin
            errors++;
            $display("FAIL hazard_before: ReadRS=%h expected %h", ReadRS, exp_before);
        end
        @(posedge Clock); #1;
        mdl[2] = 16'h2222;
        RegWrite = 1'b0;
        #1;
        checks++;
        if (ReadRS !== 16'h2222) begin
            errors++;
            $display("FAIL hazard_after: ReadRS=%h expected 2222", ReadRS);
        end
    endtask

    task automatic test_overwrite;
        do_write(2'd0, 16'h0001);
        do_write(2'd1, 16'h0002);
        do_write(2'd2, 16'h0003);
        do_write(2'd3, 16'h0004);
        do_write(2'd3, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            RS = 2'(i); RT = 2'(i);
            #1;
            checks++;
            if (ReadRS !== mdl[i] || ReadRT !== mdl[i]) begin
                errors++;
                $display("FAIL overwrite reg%0d: ReadRS=%h ReadRT=%h expected %h", i, ReadRS, ReadRT, mdl[i]);
            end
        end
        checks++;
        if (mdl[3] !== 16'hFFFF || ReadRS !== 16'hFFFF) begin
            errors++;
            $display("FAIL overwrite_last_wins: ReadRS=%h expected FFFF", ReadRS);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_rs, exp_rt;
        for (int n = 0; n < 300; n++) begin
            @(negedge Clock);
            RS = 2'($urandom_range(0, 3));
            RT = 2'($urandom_range(0, 3));
            RD = 2'($urandom_range(0, 3));
            WriteData = 16'($urandom);
            RegWrite = ($urandom_range(0, 3) != 0);
            #1;
            exp_rs = (BYPASS && RegWrite && RD == RS) ? WriteData : mdl[RS];
            exp_rt = (BYPASS && RegWrite && RD == RT) ? WriteData : mdl[RT];
            checks++;
            if (ReadRS !== exp_rs || ReadRT !== exp_rt) begin
                errors++;
                $display("FAIL random%0d: RS=%0d ReadRS=%h exp %h RT=%0d ReadRT=%h exp %h",
                         n, RS, ReadRS, exp_rs, RT, ReadRT, exp_rt);
            end
            @(posedge Clock);
            #1;
            if (RegWrite) mdl[RD] = WriteData;
        end
        @(negedge Clock);
        RegWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RS = 2'(i); RT = 2'(3 - i);
            #1;
            checks++;
            if (ReadRS !== mdl[i] || ReadRT !== mdl[3 - i]) begin
                errors++;
                $display("FAIL random_final reg%0d: ReadRS=%h exp %h ReadRT=%h exp %h",
                         i, ReadRS, mdl[i], ReadRT, mdl[3 - i]);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        RS = 2'd0; RT = 2'd0; RD = 2'd0;
        WriteData = 16'h0; RegWrite = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        test_reset;
        test_basic;
        test_write_disable;
        test_dual_read;
        test_hazard;
        test_overwrite;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
